// File: rtl/dpram_reader.sv
// Read-side sequencer for the byte-wide dual-port frame RAMs: walks the read
// port from a base address and streams the bytes out with first/last markers.
module dpram_reader #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  input  logic [7:0]    ram_data,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_first,
  output logic          out_last
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  state_t        state_reg, state_next;
  logic [AW:0]   issue_cnt_reg, acc_cnt_reg;
  logic [AW-1:0] addr_reg;
  logic          first_pend_reg;
  logic          infl_reg, infl_first_reg, infl_last_reg;
  logic [1:0]    occ_reg;
  logic          done_reg;
  // buffer word layout: {first, last, data}; entry 0 is the stream head
  logic [9:0]    buf_reg  [2];
  logic [9:0]    buf_next [2];

  logic       accept, hs, issue, last_issue, last_hs, push, pop;
  logic [2:0] pending;
  logic [1:0] occ_pop;
  logic [9:0] in_word;

  assign accept     = (state_reg == IDLE) && start && (len != '0);
  assign out_valid  = (occ_reg != 2'd0);
  assign hs         = out_valid && out_ready;
  // bytes already owed to the buffer after this cycle's handshake
  assign pending    = 3'(occ_reg) + 3'(infl_reg) - 3'(hs);
  assign issue      = (state_reg == ISSUE) && (pending < 3'd2);
  assign last_issue = issue && (issue_cnt_reg == CNT_ONE);
  assign last_hs    = hs && (acc_cnt_reg == CNT_ONE);
  assign push       = infl_reg;
  assign pop        = hs;
  assign occ_pop    = occ_reg - {1'b0, pop};
  assign in_word    = {infl_first_reg, infl_last_reg, ram_data};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      if (gi == 0) begin : g_head
        assign buf_next[gi] = (push && occ_pop == 2'(gi)) ? in_word :
                              pop                         ? buf_reg[gi+1] :
                                                            buf_reg[gi];
      end else begin : g_tail
        assign buf_next[gi] = (push && occ_pop == 2'(gi)) ? in_word : buf_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)     state_next = ISSUE;
      ISSUE:   if (last_issue) state_next = DRAIN;
      DRAIN:   if (last_hs)    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg       <= '0;
      issue_cnt_reg  <= '0;
      acc_cnt_reg    <= '0;
      first_pend_reg <= 1'b0;
      infl_reg       <= 1'b0;
      infl_first_reg <= 1'b0;
      infl_last_reg  <= 1'b0;
      occ_reg        <= 2'd0;
      done_reg       <= 1'b0;
      for (int i = 0; i < 2; i++) buf_reg[i] <= '0;
    end else begin
      if (accept) begin
        addr_reg       <= base;
        issue_cnt_reg  <= len;
        acc_cnt_reg    <= len;
        first_pend_reg <= 1'b1;
      end else if (issue) begin
        addr_reg       <= addr_reg + AW'(1);
        issue_cnt_reg  <= issue_cnt_reg - CNT_ONE;
        first_pend_reg <= 1'b0;
      end
      if (hs) acc_cnt_reg <= acc_cnt_reg - CNT_ONE;
      infl_reg       <= issue;
      infl_first_reg <= issue && first_pend_reg;
      infl_last_reg  <= last_issue;
      occ_reg        <= occ_reg + {1'b0, push} - {1'b0, pop};
      done_reg       <= (state_reg == DRAIN) && last_hs;
      buf_reg        <= buf_next;
    end
  end

  assign done      = done_reg;
  assign ram_addr  = addr_reg;
  assign out_data  = buf_reg[0][7:0];
  assign out_first = out_valid && buf_reg[0][9];
  assign out_last  = out_valid && buf_reg[0][8];

endmodule
